recon_iter_sequencer: RTL and testbench

RECON_ITER_SEQUENCER -- requirements
Module: recon_iter_sequencer

---
 rtl/recon_iter_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_recon_iter_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/recon_iter_sequencer.sv
// recon_iter_sequencer
// ---------------------------------------------------------------------------
// Sequences the buffer passes of an iterative reconstruction run. The
// sequence is: one LOAD pass fed by the level generator, then ITER_NUM
// RUN/WAIT passes. In each RUN/WAIT pass the buffer is read toward the FIR
// driver and refilled from the hard limiter.
//
// Parameters
//   MAX_SAMPLES_IN_RAM  samples per buffer pass (1..255)
//   ITER_NUM            iterations per run (1..31)
//   TIMEOUT_CYCLES      watchdog limit (1..65535). Used only when the
//                       ITER_SEQ_TIMEOUT_EN macro is defined.
//
// Optional feature macro: ITER_SEQ_TIMEOUT_EN
//   When defined, a 16-bit stall watchdog is built. The watchdog sets the
//   sticky error flag and cancels the run like an abort. When undefined,
//   error is constant 0 and a stalled source holds the FSM indefinitely.
//
// Ports
//   clock          in   rising-edge system clock
//   reset          in   synchronous, active-high
//   start          in   single-cycle run request (honoured only in IDLE)
//   abort          in   single-cycle cancel; beats start and all counter events
//   lvl_gen_valid  in   level-generator sample beat (counted in LOAD)
//   limiter_valid  in   hard-limiter sample beat (counted in RUN/WAIT)
//   iter_num       out  current iteration index
//   input_mux      out  buffer write source: 0 = level generator, 1 = limiter
//   input_enable   out  buffer write enable
//   output_enable  out  buffer read/advance enable
//   busy           out  high whenever the FSM is not in IDLE
//   done           out  one-cycle pulse on run completion
//   error          out  sticky watchdog flag
//   state_dbg      out  current FSM state, for observation only
//
// Handshake: every input is a level sampled on the rising edge. A beat is a
// cycle with its valid high; there is no back-pressure. All outputs are
// registered from the next-state values, so they change on the same edge as
// the state or counter event that causes them.
// ---------------------------------------------------------------------------
module recon_iter_sequencer #(
  parameter int MAX_SAMPLES_IN_RAM = 255,
  parameter int ITER_NUM           = 1,
  parameter int TIMEOUT_CYCLES     = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       lvl_gen_valid,
  input  logic       limiter_valid,
  output logic [4:0] iter_num,
  output logic       input_mux,
  output logic       input_enable,
  output logic       output_enable,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state_dbg
);

  if (MAX_SAMPLES_IN_RAM < 1 || MAX_SAMPLES_IN_RAM > 255 || ITER_NUM < 1 ||
      ITER_NUM > 31 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("recon_iter_sequencer: parameter out of legal range");
  end

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [7:0] MAX_CNT   = 8'(MAX_SAMPLES_IN_RAM);
  localparam logic [4:0] LAST_ITER = 5'(ITER_NUM - 1);

  logic [2:0] state, state_nxt;
  logic [7:0] wr_cnt, wr_cnt_nxt;
  logic [7:0] rd_cnt, rd_cnt_nxt;
  logic [4:0] iter_nxt;
  logic       active_beat;
  logic [7:0] wr_inc;
  logic       kill;

  // The write source that matters depends on the phase: LOAD takes
  // level-generator beats, RUN and WAIT take limiter beats.
  assign active_beat = (state == S_LOAD) ? lvl_gen_valid : limiter_valid;
  // The write count saturates at MAX_CNT, so late beats are dropped and
  // the counter never wraps.
  assign wr_inc = (active_beat && wr_cnt != MAX_CNT) ? wr_cnt + 8'd1 : wr_cnt;

  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    rd_cnt_nxt = rd_cnt;
    iter_nxt   = iter_num;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (wr_inc == MAX_CNT) begin
          state_nxt  = S_RUN;
          wr_cnt_nxt = 8'd0;
          rd_cnt_nxt = 8'd0;
        end else begin
          wr_cnt_nxt = wr_inc;
        end
      end
      S_RUN: begin
        wr_cnt_nxt = wr_inc;
        rd_cnt_nxt = rd_cnt + 8'd1;
        if (rd_cnt + 8'd1 == MAX_CNT) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // If the writes already finished during RUN, this triggers on
        // the first WAIT cycle.
        if (wr_inc == MAX_CNT) begin
          wr_cnt_nxt = 8'd0;
          rd_cnt_nxt = 8'd0;
          if (iter_num == LAST_ITER) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RUN;
            iter_nxt  = iter_num + 5'd1;
          end
        end else begin
          wr_cnt_nxt = wr_inc;
        end
      end
      S_DONE: begin
        state_nxt  = S_IDLE;
        iter_nxt   = 5'd0;
        wr_cnt_nxt = 8'd0;
        rd_cnt_nxt = 8'd0;
      end
      default: begin
        state_nxt  = S_IDLE;
        iter_nxt   = 5'd0;
        wr_cnt_nxt = 8'd0;
        rd_cnt_nxt = 8'd0;
      end
    endcase
    if (kill) begin
      state_nxt  = S_IDLE;
      wr_cnt_nxt = 8'd0;
      rd_cnt_nxt = 8'd0;
      iter_nxt   = 5'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      wr_cnt        <= 8'd0;
      rd_cnt        <= 8'd0;
      iter_num      <= 5'd0;
      input_mux     <= 1'b0;
      input_enable  <= 1'b0;
      output_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_cnt        <= wr_cnt_nxt;
      rd_cnt        <= rd_cnt_nxt;
      iter_num      <= iter_nxt;
      input_mux     <= (state_nxt == S_RUN) || (state_nxt == S_WAIT);
      input_enable  <= (state_nxt == S_LOAD) || (state_nxt == S_RUN) ||
                       (state_nxt == S_WAIT);
      output_enable <= (state_nxt == S_RUN);
      busy          <= (state_nxt != S_IDLE);
      done          <= (state_nxt == S_DONE);
    end
  end

`ifdef ITER_SEQ_TIMEOUT_EN
  logic        in_active;
  logic [15:0] wd_cnt;
  logic        wd_fire;

  assign in_active = (state == S_LOAD) || (state == S_RUN) || (state == S_WAIT);
  // The watchdog fires on the stalled cycle that would bring the count
  // up to TIMEOUT_CYCLES.
  assign wd_fire = in_active && !active_beat &&
                   (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign kill    = abort | wd_fire;

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= 16'd0;
      error  <= 1'b0;
    end else begin
      if (in_active && !active_beat && !abort && !wd_fire) wd_cnt <= wd_cnt + 16'd1;
      else wd_cnt <= 16'd0;
      if (wd_fire) error <= 1'b1;
      else if (state == S_IDLE && start && !abort) error <= 1'b0;
    end
  end
`else
  assign kill  = abort;
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_recon_iter_sequencer.sv
// Bench for recon_iter_sequencer (default build, watchdog absent).
// Reference model: run-level bookkeeping (samples loaded, reads done,
// writes done, pass index) advanced once per clock from the inputs.
module tb_recon_iter_sequencer;
  localparam int MAX  = 4;
  localparam int ITER = 3;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_WAIT = 3;
  localparam int P_DONE = 4;

  // clock / reset
  logic       clock = 1'b0;
  logic       reset;
  logic       start, abort, lvl_gen_valid, limiter_valid;
  logic [4:0] iter_num;
  logic       input_mux, input_enable, output_enable, busy, done, error;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  recon_iter_sequencer #(
    .MAX_SAMPLES_IN_RAM(MAX),
    .ITER_NUM(ITER),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .abort(abort),
    .lvl_gen_valid(lvl_gen_valid),
    .limiter_valid(limiter_valid),
    .iter_num(iter_num),
    .input_mux(input_mux),
    .input_enable(input_enable),
    .output_enable(output_enable),
    .busy(busy),
    .done(done),
    .error(error),
    .state_dbg(state_dbg)
  );

  // scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          oe_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  int m_phase, m_loaded, m_reads, m_writes, m_pass;

  function automatic void model_reset();
    m_phase = P_IDLE; m_loaded = 0; m_reads = 0; m_writes = 0; m_pass = 0;
  endfunction

  function automatic void model_tick(input logic s, input logic a, input logic lv, input logic li);
    if (a) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_IDLE: if (s) begin m_phase = P_LOAD; m_loaded = 0; end
      P_LOAD: if (lv) begin
        m_loaded++;
        if (m_loaded == MAX) begin
          m_phase = P_RUN; m_loaded = 0; m_reads = 0; m_writes = 0;
        end
      end
      P_RUN: begin
        m_reads++;
        if (li && m_writes < MAX) m_writes++;
        if (m_reads == MAX) m_phase = P_WAIT;
      end
      P_WAIT: begin
        if (li && m_writes < MAX) m_writes++;
        if (m_writes == MAX) begin
          if (m_pass == ITER - 1) m_phase = P_DONE;
          else begin m_pass++; m_phase = P_RUN; m_reads = 0; m_writes = 0; end
        end
      end
      default: model_reset();
    endcase
  endfunction

  // {pad, busy, done, input_enable, output_enable, input_mux, error, iter_num}
  function automatic logic [15:0] model_vec();
    logic b, d, ie, oe, mx;
    b  = (m_phase != P_IDLE);
    d  = (m_phase == P_DONE);
    ie = (m_phase == P_LOAD) || (m_phase == P_RUN) || (m_phase == P_WAIT);
    oe = (m_phase == P_RUN);
    mx = (m_phase == P_RUN) || (m_phase == P_WAIT);
    return {5'd0, b, d, ie, oe, mx, 1'b0, 5'(m_pass)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {5'd0, busy, done, input_enable, output_enable, input_mux, error, iter_num};
  endfunction

  // driver tasks
  task automatic step(input logic s, input logic a, input logic lv, input logic li);
    start = s; abort = a; lvl_gen_valid = lv; limiter_valid = li;
    @(posedge clock);
    model_tick(s, a, lv, li);
    exp_q.push_back(model_vec());
    #1;
    cyc++;
    check($sformatf("outs_c%0d", cyc), dut_vec(), exp_q.pop_front());
    if (output_enable) oe_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; start = 1'b0; abort = 1'b0; lvl_gen_valid = 1'b0; limiter_valid = 1'b0;
    repeat (cycles) @(posedge clock);
    model_reset();
    #1;
    check("reset_outs", dut_vec(), model_vec());
    reset = 1'b0;
  endtask

  task automatic start_and_load();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (MAX) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    do_reset(3);

    // full run, limiter keeping pace with reads
    oe_cnt = 0; done_cnt = 0;
    start_and_load();
    repeat (25) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("oe_cycles_full", 16'(oe_cnt), 16'(MAX * ITER));
    check("done_pulses_full", 16'(done_cnt), 16'd1);

    // limiter beats trailing the reads by 10 cycles in every pass
    oe_cnt = 0; done_cnt = 0;
    start_and_load();
    repeat (ITER) begin
      repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (MAX) step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("oe_cycles_delayed", 16'(oe_cnt), 16'(MAX * ITER));
    check("done_pulses_delayed", 16'(done_cnt), 16'd1);

    // abort two reads into the first RUN pass, then a clean run
    done_cnt = 0;
    start_and_load();
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("abort_busy", {15'd0, busy}, 16'd0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("abort_no_done", 16'(done_cnt), 16'd0);
    oe_cnt = 0;
    start_and_load();
    repeat (25) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("oe_cycles_after_abort", 16'(oe_cnt), 16'(MAX * ITER));
    check("done_after_abort", 16'(done_cnt), 16'd1);

    // start with abort in IDLE stays idle; start held while busy is ignored
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("start_abort_idle", {15'd0, busy}, 16'd0);
    oe_cnt = 0; done_cnt = 0;
    step(1'b1, 1'b0, 1'b0, 0);
    repeat (MAX + 3 * (MAX + 1)) step(1'b1, 1'b0, 1'b1, 1'b1);
    check("busy_start_oe", 16'(oe_cnt), 16'(MAX * ITER));
    check("busy_start_done", 16'(done_cnt), 16'd1);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);

    // reset mid-run
    done_cnt = 0;
    start_and_load();
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
    do_reset(1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("reset_no_done", 16'(done_cnt), 16'd0);

    // randomized traffic
    repeat (2000) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
